// File: rtl/spi_dump_pkg.sv
// Shared opcodes and state encodings for the SPI capture/replay controller.
package spi_dump_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_CLEAR  = 8'h01;
    localparam logic [7:0] OP_RECORD = 8'h02;
    localparam logic [7:0] OP_DUMP   = 8'h03;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GET_LEN = 2'd1,
        RECORD  = 2'd2,
        DUMP    = 2'd3
    } state_t;

    // Per-word replay sequence: present address, capture RAM output, wait for the SPI side.
    typedef enum logic [1:0] {
        DP_ISSUE = 2'd0,
        DP_LOAD  = 2'd1,
        DP_SEND  = 2'd2
    } dump_phase_t;

endpackage

// File: rtl/spi_dump_ctrl_if.sv
// Word-level handshake between the spi_slave core (master) and the dump controller (slave).
interface spi_dump_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ack;
    logic              tx_ready;
    logic              tx_en;
    logic [DATA_W-1:0] tx_data;

    modport master (
        output rx_valid, rx_data, tx_ready,
        input  rx_ack, tx_en, tx_data
    );

    modport slave (
        input  rx_valid, rx_data, tx_ready,
        output rx_ack, tx_en, tx_data
    );
endinterface

// File: rtl/spi_dump_ram.sv
// Simple dual-port RAM: synchronous write, registered read (1-cycle latency), no reset so it maps to block RAM.
module spi_dump_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/spi_dump_ctrl.sv
// Command-driven capture/replay buffer between spi_slave word interfaces and an inferred RAM.
// Build option SPI_DUMP_CSUM_EN appends an XOR checksum word to every DUMP.
module spi_dump_ctrl
    import spi_dump_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    spi_dump_ctrl_if.slave  spi,
    output logic [ADDR_W:0] level,
    output logic            overflow,
    output logic            cmd_err,
    output logic [1:0]      state
);
    localparam int              DEPTH_I = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH   = DEPTH_I[ADDR_W:0];

    state_t            state_q, state_d;
    dump_phase_t       phase_q, phase_d;
    logic              rx_valid_q, rx_ack_q, rx_ack_d;
    logic              hold_q, hold_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d, sent_q, sent_d;
    logic [DATA_W-1:0] remaining_q, remaining_d;
    logic              overflow_q, overflow_d, cmd_err_q, cmd_err_d;
    logic              tx_pend_q, tx_pend_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
`ifdef SPI_DUMP_CSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              csum_done_q, csum_done_d;
`endif

    logic              rx_edge, word_valid, dump_end, adv;
    logic [DATA_W-1:0] word;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    spi_dump_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (word),
        .re    (1'b1),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign rx_edge    = spi.rx_valid & ~rx_valid_q;
    // A word that arrived on the DUMP completion cycle is replayed from the hold register in IDLE.
    assign word_valid = rx_edge | hold_q;
    assign word       = hold_q ? hold_data_q : spi.rx_data;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        rx_ack_d    = rx_edge;
        hold_d      = 1'b0;
        hold_data_d = hold_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        sent_d      = sent_q;
        remaining_d = remaining_q;
        overflow_d  = overflow_q;
        cmd_err_d   = cmd_err_q;
        tx_pend_d   = (state_q == DUMP) ? tx_pend_q : 1'b0;
        tx_data_d   = tx_data_q;
        ram_we      = 1'b0;
        dump_end    = 1'b0;
        adv         = 1'b1;
`ifdef SPI_DUMP_CSUM_EN
        csum_d      = csum_q;
        csum_done_d = csum_done_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (word_valid) begin
                    unique case (word[7:0])
                        OP_NOP: begin
                            tx_pend_d = spi.tx_ready;
                            tx_data_d = word;
                        end
                        OP_CLEAR: begin
                            wr_ptr_d   = '0;
                            level_d    = '0;
                            overflow_d = 1'b0;
                            cmd_err_d  = 1'b0;
                        end
                        OP_RECORD: state_d = GET_LEN;
                        OP_DUMP: begin
                            rd_ptr_d = '0;
                            sent_d   = '0;
                            phase_d  = DP_ISSUE;
                            state_d  = DUMP;
`ifdef SPI_DUMP_CSUM_EN
                            csum_d      = '0;
                            csum_done_d = 1'b0;
`endif
                        end
                        default: cmd_err_d = 1'b1;
                    endcase
                end
            end
            GET_LEN: begin
                if (word_valid) begin
                    if (word == '0) begin
                        state_d = IDLE;
                    end else begin
                        remaining_d = word;
                        state_d     = RECORD;
                    end
                end
            end
            RECORD: begin
                if (word_valid) begin
                    if (!level_q[ADDR_W]) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                        level_d  = level_q + (ADDR_W+1)'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                    tx_pend_d   = spi.tx_ready;
                    tx_data_d   = word;
                    remaining_d = remaining_q - DATA_W'(1);
                    if (remaining_q == DATA_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            DUMP: begin
                unique case (phase_q)
                    DP_ISSUE: begin
                        if (sent_q != level_q) begin
                            phase_d = DP_LOAD;
                        end
`ifdef SPI_DUMP_CSUM_EN
                        else if (!csum_done_q) begin
                            tx_data_d   = csum_q;
                            tx_pend_d   = 1'b1;
                            csum_done_d = 1'b1;
                            phase_d     = DP_SEND;
                        end
`endif
                        else begin
                            dump_end = 1'b1;
                        end
                    end
                    DP_LOAD: begin
                        tx_data_d = ram_rdata;
                        tx_pend_d = 1'b1;
                        phase_d   = DP_SEND;
`ifdef SPI_DUMP_CSUM_EN
                        csum_d = csum_q ^ ram_rdata;
`endif
                    end
                    default: begin
`ifdef SPI_DUMP_CSUM_EN
                        adv = ~csum_done_q;
`endif
                        if (spi.tx_ready) begin
                            tx_pend_d = 1'b0;
                            phase_d   = DP_ISSUE;
                            if (adv) begin
                                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                                sent_d   = sent_q + (ADDR_W+1)'(1);
                            end
                        end
                    end
                endcase
                if (dump_end) begin
                    state_d     = IDLE;
                    hold_d      = rx_edge;
                    hold_data_d = spi.rx_data;
                end else if (rx_edge) begin
                    cmd_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= DP_ISSUE;
            rx_valid_q  <= 1'b0;
            rx_ack_q    <= 1'b0;
            hold_q      <= 1'b0;
            hold_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            sent_q      <= '0;
            remaining_q <= '0;
            overflow_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            tx_pend_q   <= 1'b0;
            tx_data_q   <= '0;
`ifdef SPI_DUMP_CSUM_EN
            csum_q      <= '0;
            csum_done_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            rx_valid_q  <= spi.rx_valid;
            rx_ack_q    <= rx_ack_d;
            hold_q      <= hold_d;
            hold_data_q <= hold_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            sent_q      <= sent_d;
            remaining_q <= remaining_d;
            overflow_q  <= overflow_d;
            cmd_err_q   <= cmd_err_d;
            tx_pend_q   <= tx_pend_d;
            tx_data_q   <= tx_data_d;
`ifdef SPI_DUMP_CSUM_EN
            csum_q      <= csum_d;
            csum_done_q <= csum_done_d;
`endif
        end
    end

    // Gating with the live tx_ready keeps a strobe from ever landing on a busy spi_slave buffer.
    assign spi.tx_en   = tx_pend_q & spi.tx_ready;
    assign spi.tx_data = tx_data_q;
    assign spi.rx_ack  = rx_ack_q;
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign cmd_err     = cmd_err_q;
    assign state       = state_q;
endmodule

// File: tb/tb_spi_dump_ctrl.sv
// Directed plus randomized bench for spi_dump_ctrl, checked against a word-level buffer model.
// Honours SPI_DUMP_CSUM_EN to expect the trailing checksum word.
module tb_spi_dump_ctrl;
    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [AW:0] level;
    logic       overflow, cmd_err;
    logic [1:0] state;

    always #5 clk = ~clk;

    spi_dump_ctrl_if #(.DATA_W(DW)) bus ();

    spi_dump_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .spi      (bus),
        .level    (level),
        .overflow (overflow),
        .cmd_err  (cmd_err),
        .state    (state)
    );

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int viol_cnt = 0;
    int words = 0;
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];

    // Reference model: stored words as a queue, plus command mode and flags.
    logic [DW-1:0] m_store[$];
    int            m_mode;  // 0 = awaiting opcode, 1 = awaiting count, 2 = recording
    int            m_rem;
    logic          m_ovf, m_err;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.tx_en) begin
                got_q.push_back(bus.tx_data);
                if (!bus.tx_ready) viol_cnt++;
            end
            if (bus.rx_ack) ack_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_store.delete();
        m_mode = 0;
        m_rem  = 0;
        m_ovf  = 1'b0;
        m_err  = 1'b0;
    endfunction

    function automatic void m_word(input logic [DW-1:0] w, input logic rdy);
        logic [DW-1:0] x;
        logic [7:0]    op;
        op = w[7:0];
        if (m_mode == 0) begin
            if (op == 8'h00) begin
                if (rdy) exp_q.push_back(w);
            end else if (op == 8'h01) begin
                m_store.delete();
                m_ovf = 1'b0;
                m_err = 1'b0;
            end else if (op == 8'h02) begin
                m_mode = 1;
            end else if (op == 8'h03) begin
                x = '0;
                foreach (m_store[i]) begin
                    exp_q.push_back(m_store[i]);
                    x = x ^ m_store[i];
                end
`ifdef SPI_DUMP_CSUM_EN
                exp_q.push_back(x);
`endif
            end else begin
                m_err = 1'b1;
            end
        end else if (m_mode == 1) begin
            m_rem  = int'(w);
            m_mode = (w == 0) ? 0 : 2;
        end else begin
            if (m_store.size() < DEPTH) m_store.push_back(w);
            else m_ovf = 1'b1;
            if (rdy) exp_q.push_back(w);
            m_rem--;
            if (m_rem == 0) m_mode = 0;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] w, input logic rdy);
        bus.tx_ready = rdy;
        bus.rx_data  = w;
        bus.rx_valid = 1'b1;
        tick(2);
        bus.rx_valid = 1'b0;
        tick(2);
        m_word(w, rdy);
        words++;
    endtask

    // DUMP with tx_ready randomly toggling; bounded wait for the FSM to come home.
    task automatic do_dump();
        logic [DW-1:0] w;
        int n;
        w = {8'($urandom_range(0, 255)), 8'h03};
        n = 0;
        bus.rx_data  = w;
        bus.rx_valid = 1'b1;
        while (n < 400) begin
            bus.tx_ready = 1'($urandom_range(0, 1));
            tick(1);
            n++;
            if (n == 2) bus.rx_valid = 1'b0;
            if (n >= 4 && state == 2'd0) break;
        end
        bus.tx_ready = 1'b1;
        tick(2);
        m_word(w, 1'b1);
        words++;
    endtask

    task automatic verify(input string tag);
        int bad;
        bad = 0;
        chk({tag, ".level"}, 32'(level), 32'(m_store.size()));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".cmd_err"}, 32'(cmd_err), 32'(m_err));
        chk({tag, ".state"}, 32'(state), 32'(m_mode));
        chk({tag, ".tx_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        chk({tag, ".tx_words"}, 32'(bad), 32'd0);
        chk({tag, ".acks"}, 32'(ack_cnt), 32'(words));
        chk({tag, ".tx_ready_viol"}, 32'(viol_cnt), 32'd0);
        $display("txn %s level=%0d overflow=%0b cmd_err=%0b tx_words=%0d", tag, level, overflow, cmd_err, got_q.size());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".rx_ack"}, 32'(bus.rx_ack), 32'd0);
        chk({tag, ".tx_en"}, 32'(bus.tx_en), 32'd0);
        chk({tag, ".tx_data"}, 32'(bus.tx_data), 32'd0);
        chk({tag, ".level"}, 32'(level), 32'd0);
        chk({tag, ".overflow"}, 32'(overflow), 32'd0);
        chk({tag, ".cmd_err"}, 32'(cmd_err), 32'd0);
        chk({tag, ".state"}, 32'(state), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] w;
        int r, nlen;
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.tx_ready = 1'b1;
        m_reset();
        tick(3);
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick(2);

        // Record three words, then dump them back with tx_ready toggling.
        send(16'h0002, 1'b1);
        send(16'h0003, 1'b1);
        send(16'h1111, 1'b1);
        send(16'h2222, 1'b1);
        send(16'h3333, 1'b1);
        verify("s1_record");
        do_dump();
        verify("s2_dump");

        // Overflow with a 4-deep buffer.
        send(16'h0001, 1'b1);
        send(16'h0002, 1'b1);
        send(16'h0006, 1'b1);
        for (int i = 1; i <= 6; i++) send(DW'(i), 1'b1);
        verify("s3_overflow");
        do_dump();
        verify("s3_dump");
        send(16'h0001, 1'b1);
        verify("s3_clear");

        // NOP echo and unknown opcode.
        send(16'h00AB, 1'b1);
        verify("s4_nop");
        send(16'h0007, 1'b1);
        verify("s4_badop");

        // Reset in the middle of a RECORD burst.
        send(16'h0001, 1'b1);
        send(16'h0002, 1'b1);
        send(16'h0003, 1'b1);
        send(16'h0A0A, 1'b1);
        bus.rx_data  = 16'h0B0B;
        bus.rx_valid = 1'b1;
        tick(1);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("s5_in_reset");
        tick(2);
        bus.rx_valid = 1'b0;
        tick(1);
        reset = 1'b0;
        m_reset();
        got_q.delete();
        exp_q.delete();
        ack_cnt = 0;
        words   = 0;
        tick(2);
        do_dump();
        verify("s5_after_reset");

        // Zero-length RECORD; the next word is an opcode again.
        send(16'h0002, 1'b1);
        send(16'h0000, 1'b1);
        send(16'h5500, 1'b1);
        verify("s6_zero_len");

        // Randomized command mix.
        for (int t = 0; t < 30; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                w = {8'($urandom_range(0, 255)), 8'h00};
                send(w, 1'($urandom_range(0, 1)));
            end else if (r == 3) begin
                send(16'h0001, 1'b1);
            end else if (r <= 5) begin
                nlen = $urandom_range(0, 6);
                send(16'h0002, 1'b1);
                send(DW'(nlen), 1'b1);
                for (int k = 0; k < nlen; k++) send(DW'($urandom), 1'($urandom_range(0, 1)));
            end else if (r <= 7) begin
                do_dump();
            end else begin
                w = {8'($urandom_range(0, 255)), 8'($urandom_range(4, 255))};
                send(w, 1'b1);
            end
            verify($sformatf("rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_dump_ctrl.md
Name: spi_dump_ctrl

Overview:
Command-driven capture/replay buffer between the spi_slave receive/transmit word interfaces and an on-chip RAM. The host sends opcode words to clear the buffer, record a counted burst of words, or dump the stored words back over SPI. Depth and word width are parametrised. It replaces the fixed echo-and-store logic in the spi_dump top and targets iCE40 block RAM through an inferred RAM.

Parameters:
DATA_W, 16, SPI word width; must be >= 8, since the opcode sits in bits [7:0].
ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W words.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
rx_valid  in  1  spi_slave rd_data_available; new word on its rising edge.
rx_data  in  DATA_W  spi_slave rd_data.
rx_ack  out  1  one-cycle pulse acknowledging each accepted rx word.
tx_ready  in  1  spi_slave wr_buffer_free.
tx_en  out  1  one-cycle write strobe to spi_slave.
tx_data  out  DATA_W  word to send; valid while tx_en=1.
level  out  ADDR_W+1  number of stored words, 0..DEPTH.
overflow  out  1  sticky; a RECORD word was discarded because the buffer was full.
cmd_err  out  1  sticky; unknown opcode, or a word received during DUMP.
state  out  2  current FSM state, for LEDs and debug.

Behaviour:
- Reset values: rx_ack=0, tx_en=0, tx_data=0, level=0, overflow=0, cmd_err=0, state=IDLE. Internal wr_ptr, rd_ptr and remaining are all 0. RAM contents are not cleared.
- Reset mid-operation aborts any RECORD or DUMP. Previously stored data is considered lost (level=0).
- Rx detect: register rx_valid; a word is accepted when rx_valid=1 and its previous value was 0. rx_ack pulses on the cycle after detection.
- Opcodes are decoded from rx_data[7:0]; upper bits are ignored. 0x00 NOP, 0x01 CLEAR, 0x02 RECORD, 0x03 DUMP.
- IDLE:
  - NOP: echo the word on tx if tx_ready=1; otherwise drop it silently.
  - CLEAR: wr_ptr=0, level=0, overflow=0, cmd_err=0 on the next cycle.
  - RECORD: go to GET_LEN.
  - DUMP: rd_ptr=0, go to DUMP.
  - Any other opcode: set cmd_err, stay in IDLE.
- GET_LEN: the next word is the count N (full DATA_W, unsigned). N=0 returns to IDLE. Otherwise remaining=N and the FSM goes to RECORD.
- RECORD: each accepted word is handled as follows.
  - If level<DEPTH: write RAM[wr_ptr], then wr_ptr++ (wraps modulo DEPTH) and level++.
  - If level=DEPTH: discard the word and set overflow.
  - In both cases, echo the word on tx if tx_ready=1.
  - remaining-- on every word; when it reaches 0, go to IDLE on the same cycle as the last word's write.
  - Words append after existing contents; there is no implicit clear.
- DUMP: the RAM has 1-cycle read latency.
  - Issue the read of rd_ptr, then wait for tx_ready=1 with the data held.
  - Pulse tx_en with tx_data=RAM[rd_ptr], then rd_ptr++.
  - After level words have been sent, return to IDLE. level=0 returns to IDLE immediately with no tx.
  - Rx words arriving during DUMP are acked and dropped, and set cmd_err.
- tx_en is never asserted while tx_ready=0, and at most one tx_en is issued per accepted rx word (NOP/RECORD) or per dumped word.
- A new rx edge on the same cycle as a DUMP completion is processed in IDLE on the next cycle; it is not lost.
- level saturates at DEPTH; the pointer wrap is only reachable after CLEAR.

Optional Feature:
SPI_DUMP_CSUM_EN
- Defined: DUMP sends one extra trailing word equal to the XOR of all dumped words. With level=0 it sends a single word 0. The checksum register clears on DUMP entry.
- Undefined: no trailing word and no checksum logic.

Decomposition:
- Package spi_dump_pkg holds:
  - opcode localparams OP_NOP, OP_CLEAR, OP_RECORD, OP_DUMP;
  - state encoding IDLE=0, GET_LEN=1, RECORD=2, DUMP=3.
- Sub-module spi_dump_ram(DATA_W, ADDR_W): simple dual-port RAM with a synchronous write port and a registered read port (1-cycle latency), inferable as SB_RAM40_4K.

Test Plan:
1. Reset, then send 0x0002, 0x0003, 0x1111, 0x2222, 0x3333 -> level=3, three echoes 0x1111/0x2222/0x3333, state returns to IDLE, overflow=0.
2. Continue from scenario 1 and send 0x0003 with tx_ready toggling -> tx_data sequence 0x1111, 0x2222, 0x3333, no tx_en while tx_ready=0. With SPI_DUMP_CSUM_EN defined, a fourth word 0x0000 (0x1111^0x2222^0x3333).
3. Use ADDR_W=2, CLEAR, then RECORD N=6 with words 1..6 -> level=4, overflow=1, a DUMP returns 1,2,3,4, and CLEAR drops overflow to 0.
4. Send 0x00AB in IDLE -> echo 0x00AB. Send 0x0007 -> cmd_err=1, no tx, state IDLE.
5. Assert reset during the second RECORD word, then release and send DUMP -> level=0, no tx word (or only checksum 0 if CSUM enabled), all outputs at their reset values.
6. Send RECORD with N=0 -> back to IDLE, level unchanged, the following word is decoded as an opcode.
